// File: rtl/ll_cmd_frontend_if.sv
// Command handshake between the switch front end and the linked-list engine.
// The master presents the FIFO head; the slave accepts it with cmd_ready.
interface ll_cmd_frontend_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ll_cmd_frontend.sv
// Switch synchroniser, debouncer and one-shot command issuer feeding a small
// first-word-fall-through FIFO that drives the linked-list engine.
module ll_cmd_frontend #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CMD_DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [15:0]               i_sw_in,
    ll_cmd_frontend_if.master         cmd_if,
    output logic                      o_fifo_full,
    output logic [7:0]                o_drop_cnt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(CMD_DEPTH);

    // {opcode[2:0], data[7:0]} travels as one 11-bit word
    logic [10:0]   w_sw;
    logic          w_unused_sw;
    logic [10:0]   r_s1;
    logic [10:0]   r_s2;
    logic [10:0]   r_s2_prev;
    logic [CW-1:0] r_cnt;
    logic [10:0]   r_stable;
    logic          r_loaded;
    logic          r_armed;
    logic          w_same;
    logic          w_load;

    logic [9:0]    r_mem [CMD_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_drop_cnt;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_wr;

    assign w_sw        = {i_sw_in[15:13], i_sw_in[7:0]};
    assign w_unused_sw = ^i_sw_in[12:8];

    assign w_same = (r_s2 == r_s2_prev);
    assign w_load = w_same && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_s2_prev <= '0;
            r_cnt     <= '0;
            r_stable  <= '0;
            r_loaded  <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_s1      <= w_sw;
            r_s2      <= r_s1;
            r_s2_prev <= r_s2;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CW'(DEBOUNCE_CYCLES)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) begin
                r_stable <= r_s2;
                r_loaded <= 1'b1;
            end
            // Idle only counts once a debounced value has actually been loaded,
            // so an opcode held through reset cannot fire on release.
            if (!r_stable[10]) begin
                if (r_loaded) begin
                    r_armed <= 1'b1;
                end
            end else if (r_armed) begin
                r_armed <= 1'b0;
            end
        end
    end

    assign w_push  = r_stable[10] && r_armed;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(CMD_DEPTH));
    assign w_pop   = !w_empty && cmd_if.cmd_ready;
    // When full, a simultaneous pop frees the slot the push lands in
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_stable[9:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign cmd_if.cmd_valid = !w_empty;
    assign cmd_if.cmd_op    = w_empty ? 2'b00 : r_mem[r_rd_ptr][9:8];
    assign cmd_if.cmd_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
    assign o_fifo_full      = w_full;
    assign o_drop_cnt       = r_drop_cnt;
endmodule
